// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag bit positions and
// FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_MUL = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_ROL = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;
   localparam logic [3:0] OP_SRA = 4'b1011;

   localparam int F_S = 3;
   localparam int F_Z = 2;
   localparam int F_C = 1;
   localparam int F_V = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MULT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_if.sv
// Operation/result handshake bundle. Both sides use valid/ready: a beat
// transfers on a rising edge where valid and ready are both high.
interface alu_if #(parameter int WIDTH = 16) ();

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic [1:0]       dbg_state;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flags, dbg_state
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flags, dbg_state
   );

endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/ROL/SRL/SRA (op 00/01/10/11) using the
// full b as shift amount; carry is the last bit shifted out.
module alu_shifter #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0]     n;
   logic               big;
   logic [WIDTH:0]     sll_t;
   logic [WIDTH:0]     srl_t;
   logic [WIDTH:0]     sra_t;
   logic [2*WIDTH-1:0] rol_t;

   assign n   = b[SHW-1:0];
   assign big = |b[WIDTH-1:SHW];

   // One guard bit beyond the data catches the last bit shifted out.
   assign sll_t = {1'b0, a} << n;
   assign srl_t = {a, 1'b0} >> n;
   assign sra_t = $signed({a, 1'b0}) >>> n;
   assign rol_t = {a, a} << n;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         2'b00: begin
            if (!big) begin
               result = sll_t[WIDTH-1:0];
               carry  = sll_t[WIDTH];
            end
         end
         2'b01: begin
            result = rol_t[2*WIDTH-1:WIDTH];
            carry  = (n != '0) & rol_t[WIDTH];
         end
         2'b10: begin
            if (!big) begin
               result = srl_t[WIDTH:1];
               carry  = srl_t[0];
            end
         end
         default: begin
            if (big) begin
               result = {WIDTH{a[WIDTH-1]}};
               carry  = a[WIDTH-1];
            end else begin
               result = sra_t[WIDTH:1];
               carry  = sra_t[0];
            end
         end
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/shift, iterative shift-add
// multiplier, one-entry registered output buffer with flags {S,Z,C,V}.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic   clk,
   input  logic   rst,
   alu_if.slave   bus
);

   localparam int SHW = $clog2(WIDTH);

   logic [1:0]         state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [3:0]         flags_q, flags_d;
   logic               out_valid_q, out_valid_d;

   logic               out_free;
   logic               accept;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH-1:0]   sh_res;
   logic               sh_c;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [2*WIDTH-1:0] acc_step;
   logic               load;
   logic [WIDTH-1:0]   load_res;
   logic [3:0]         load_flags;

   function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                           input logic c, input logic v);
      logic [3:0] f;
      f      = '0;
      f[F_S] = r[WIDTH-1];
      f[F_Z] = (r == '0);
      f[F_C] = c;
      f[F_V] = v;
      return f;
   endfunction

   alu_shifter #(.WIDTH(WIDTH)) u_shifter (
      .a      (bus.a),
      .b      (bus.b),
      .op     (bus.op[1:0]),
      .result (sh_res),
      .carry  (sh_c)
   );

   assign out_free     = !out_valid_q | bus.out_ready;
   assign bus.in_ready = (state_q == ST_IDLE) & out_free;
   assign accept       = bus.in_valid & bus.in_ready;
   assign add_sum      = {1'b0, bus.a} + {1'b0, bus.b};
   assign sub_diff     = {1'b0, bus.a} - {1'b0, bus.b};
   assign acc_step     = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.op)
         OP_ADD: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &
                      (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_diff[WIDTH-1:0];
            alu_c   = sub_diff[WIDTH];
            alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &
                      (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: alu_res = bus.a & bus.b;
         OP_OR:  alu_res = bus.a | bus.b;
         OP_XOR: alu_res = bus.a ^ bus.b;
         OP_SLL, OP_ROL, OP_SRL, OP_SRA: begin
            alu_res = sh_res;
            alu_c   = sh_c;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      load       = 1'b0;
      load_res   = '0;
      load_flags = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (bus.op == OP_MUL) begin
                  state_d  = ST_MULT;
                  cnt_d    = '0;
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, bus.a};
                  mplier_d = bus.b;
               end else begin
                  load       = 1'b1;
                  load_res   = alu_res;
                  load_flags = mk_flags(alu_res, alu_c, alu_v);
               end
            end
         end
         ST_MULT: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 1)) begin
               cnt_d = '0;
               if (out_free) begin
                  state_d    = ST_IDLE;
                  load       = 1'b1;
                  load_res   = acc_step[WIDTH-1:0];
                  load_flags = mk_flags(acc_step[WIDTH-1:0],
                                        |acc_step[2*WIDTH-1:WIDTH], 1'b0);
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_free) begin
               state_d    = ST_IDLE;
               load       = 1'b1;
               load_res   = acc_q[WIDTH-1:0];
               load_flags = mk_flags(acc_q[WIDTH-1:0],
                                     |acc_q[2*WIDTH-1:WIDTH], 1'b0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A load on a consume edge replaces the old entry with no bubble.
   always_comb begin
      out_valid_d = load | (out_valid_q & !bus.out_ready);
      result_d    = load ? load_res : result_q;
      flags_d     = load ? load_flags : flags_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flags     = flags_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed cases, latency/back-pressure/reset
// checks and randomized traffic scored against an arithmetic reference model.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;

   logic clk;
   logic rst;

   alu_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [19:0]  exp_q[$];
   logic         hold_valid;
   logic [W-1:0] hold_res;
   logic [3:0]   hold_flags;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model: {S,Z,C,V, result}
   function automatic logic [19:0] model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      logic [15:0]     r;
      logic            c;
      logic            v;
      int              sx, sy, ss, n, k;
      longint unsigned p;
      r = '0; c = 1'b0; v = 1'b0;
      sx = $signed(x);
      sy = $signed(y);
      n  = int'(y);
      case (o)
         OP_ADD: begin
            p  = longint'(x) + longint'(y);
            r  = p[15:0];
            c  = (p > 65535);
            ss = sx + sy;
            v  = (ss > 32767) || (ss < -32768);
         end
         OP_SUB: begin
            r  = x - y;
            c  = (x < y);
            ss = sx - sy;
            v  = (ss > 32767) || (ss < -32768);
         end
         OP_AND: r = x & y;
         OP_OR:  r = x | y;
         OP_XOR: r = x ^ y;
         OP_MUL: begin
            p = longint'(x) * longint'(y);
            r = p[15:0];
            c = ((p >> 16) != 0);
         end
         OP_SLL: begin
            r = x;
            if (n >= 16) r = '0;
            else for (int i = 0; i < n; i++) begin c = r[15]; r = r << 1; end
         end
         OP_SRL: begin
            r = x;
            if (n >= 16) r = '0;
            else for (int i = 0; i < n; i++) begin c = r[0]; r = r >> 1; end
         end
         OP_SRA: begin
            r = x;
            if (n >= 16) begin r = {16{x[15]}}; c = x[15]; end
            else for (int i = 0; i < n; i++) begin c = r[0]; r = {r[15], r[15:1]}; end
         end
         OP_ROL: begin
            r = x;
            k = n % 16;
            for (int i = 0; i < k; i++) r = {r[14:0], r[15]};
            c = (k != 0) ? r[0] : 1'b0;
         end
         default: r = '0;
      endcase
      return {r[15], (r == 16'h0), c, v, r};
   endfunction

   // driver: one clock cycle, entered and left just after a falling edge
   task automatic step(input logic iv, input logic [3:0] o, input logic [15:0] aa,
                       input logic [15:0] bb, input logic ordy);
      logic [19:0] e;
      bus.in_valid  = iv;
      bus.op        = o;
      bus.a         = aa;
      bus.b         = bb;
      bus.out_ready = ordy;
      #1;
      if (hold_valid) begin
         check("hold_valid", bus.out_valid, 1'b1);
         check("hold_result", bus.result, hold_res);
         check("hold_flags", bus.flags, hold_flags);
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(o, aa, bb));
      if (bus.out_valid && bus.out_ready) begin
         check("sb_pending", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_result", bus.result, e[15:0]);
            check("sb_flags", bus.flags, e[19:16]);
         end
      end
      hold_valid = bus.out_valid && !bus.out_ready;
      hold_res   = bus.result;
      hold_flags = bus.flags;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst        = 1'b0;
      hold_valid = 1'b0;
      exp_q.delete();
   endtask

   task automatic directed(input string tag, input logic [3:0] o, input logic [15:0] aa,
                           input logic [15:0] bb, input logic [15:0] er, input logic [3:0] ef);
      step(1'b1, o, aa, bb, 1'b1);
      check({tag, "_valid"}, bus.out_valid, 1'b1);
      check({tag, "_result"}, bus.result, er);
      check({tag, "_flags"}, bus.flags, ef);
   endtask

   initial begin
      logic [3:0]  ro;
      logic [15:0] rb;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      hold_valid    = 1'b0;
      hold_res      = '0;
      hold_flags    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_result", bus.result, 16'h0);
      check("rst_flags", bus.flags, 4'h0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_state", bus.dbg_state, ST_IDLE);

      // directed single-cycle ops, back to back
      directed("add_ovf",  OP_ADD, 16'd40000, 16'd40000, 16'd14464, 4'b0011);
      directed("sub_neg",  OP_SUB, 16'd34,    16'd35,    16'hFFFF,  4'b1010);
      directed("sub_zero", OP_SUB, 16'd9999,  16'd9999,  16'h0000,  4'b0100);
      directed("sra_4",    OP_SRA, 16'hFF00,  16'd4,     16'hFFF0,  4'b1000);
      directed("sra_20",   OP_SRA, 16'hFF00,  16'd20,    16'hFFFF,  4'b1010);
      directed("sll_8",    OP_SLL, 16'hFF00,  16'd8,     16'h0000,  4'b0110);
      directed("sll_9",    OP_SLL, 16'hFF00,  16'd9,     16'h0000,  4'b0100);
      directed("rol_4",    OP_ROL, 16'hFF00,  16'd4,     16'hF00F,  4'b1010);
      directed("srl_16",   OP_SRL, 16'hFF00,  16'd16,    16'h0000,  4'b0100);
      directed("rol_16",   OP_ROL, 16'h8001,  16'd16,    16'h8001,  4'b1000);
      directed("bad_op",   4'b1111, 16'h1234, 16'h5678,  16'h0000,  4'b0100);

      // multiply latency
      step(1'b1, OP_MUL, 16'd300, 16'd300, 1'b1);
      for (int k = 1; k <= W; k++) begin
         check("mul_wait_valid", bus.out_valid, 1'b0);
         check("mul_wait_in_ready", bus.in_ready, 1'b0);
         check("mul_wait_state", bus.dbg_state, ST_MULT);
         step(1'b1, OP_ADD, 16'd7, 16'd7, 1'b1);
      end
      check("mul_valid", bus.out_valid, 1'b1);
      check("mul_result", bus.result, 16'd24464);
      check("mul_flags", bus.flags, 4'b0010);
      check("mul_in_ready", bus.in_ready, 1'b1);
      directed("after_mul", OP_ADD, 16'd1, 16'd2, 16'd3, 4'b0000);

      // back-pressure
      step(1'b0, OP_ADD, 16'd0, 16'd0, 1'b1);
      check("drain_valid", bus.out_valid, 1'b0);
      step(1'b1, OP_ADD, 16'd5, 16'd8, 1'b0);
      check("bp_result", bus.result, 16'd13);
      for (int k = 0; k < 3; k++) begin
         check("bp_in_ready", bus.in_ready, 1'b0);
         step(1'b1, OP_XOR, 16'h00FF, 16'h0F0F, 1'b0);
         check("bp_stable", bus.result, 16'd13);
      end
      directed("bp_swap", OP_XOR, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000);
      step(1'b1, OP_MUL, 16'd7, 16'd9, 1'b1);
      for (int k = 0; k < W; k++) step(1'b0, OP_ADD, 16'd0, 16'd0, 1'b0);
      check("bp_mul_valid", bus.out_valid, 1'b1);
      check("bp_mul_result", bus.result, 16'd63);
      repeat (2) step(1'b0, OP_ADD, 16'd0, 16'd0, 1'b0);
      step(1'b0, OP_ADD, 16'd0, 16'd0, 1'b1);

      // reset in the middle of a multiply
      step(1'b1, OP_MUL, 16'd300, 16'd300, 1'b1);
      repeat (5) step(1'b0, OP_ADD, 16'd0, 16'd0, 1'b1);
      check("mid_state", bus.dbg_state, ST_MULT);
      do_reset();
      #1;
      check("mid_rst_valid", bus.out_valid, 1'b0);
      check("mid_rst_in_ready", bus.in_ready, 1'b1);
      check("mid_rst_state", bus.dbg_state, ST_IDLE);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, OP_ADD, 16'd0, 16'd0, 1'b1);
         check("mid_rst_no_prod", bus.out_valid, 1'b0);
      end

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         ro = 4'($urandom_range(0, 15));
         rb = 16'($urandom);
         if (ro[3] && ($urandom_range(0, 1) == 1)) rb = 16'($urandom_range(0, 20));
         step($urandom_range(0, 3) != 0, ro, 16'($urandom), rb, $urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < 100 && exp_q.size() > 0; k++) step(1'b0, OP_ADD, 16'd0, 16'd0, 1'b1);
      check("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
